// File: rtl/control_sequencer.sv
// control_sequencer: T1..T6 one-hot ring controller for the 8-bit datapath.
// Optional macro CTRL_SINGLE_STEP_EN adds a step port gating advance/strobes.
module control_sequencer #(
  parameter int unsigned     OP_W   = 4,
  parameter logic [OP_W-1:0] OP_LDA = 4'h0,
  parameter logic [OP_W-1:0] OP_ADD = 4'h1,
  parameter logic [OP_W-1:0] OP_SUB = 4'h2,
  parameter logic [OP_W-1:0] OP_OUT = 4'hE,
  parameter logic [OP_W-1:0] OP_HLT = 4'hF
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [OP_W-1:0] opcode,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [5:0]      tstate,
  output logic            cp,
  output logic            ep,
  output logic            lm,
  output logic            ce,
  output logic            li,
  output logic            ei,
  output logic            la,
  output logic            ea,
  output logic            su,
  output logic            eu,
  output logic            lb,
  output logic            lo,
  output logic            hlt
);

  logic       adv;
  logic [5:0] ring;
  logic [5:0] ring_nx;
  logic       halted;
  logic       halted_nx;

`ifdef CTRL_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      ring   <= 6'b000001;
      halted <= 1'b0;
    end else begin
      ring   <= ring_nx;
      halted <= halted_nx;
    end
  end

  // HLT parks the ring on T4 instead of rotating
  always_comb begin
    ring_nx   = ring;
    halted_nx = halted;
    if (!halted && adv) begin
      if (ring[3] && opcode == OP_HLT)
        halted_nx = 1'b1;
      else
        ring_nx = {ring[4:0], ring[5]};
    end
  end

  always_comb begin
    cp = 1'b0;
    ep = 1'b0;
    lm = 1'b0;
    ce = 1'b0;
    li = 1'b0;
    ei = 1'b0;
    la = 1'b0;
    ea = 1'b0;
    su = 1'b0;
    eu = 1'b0;
    lb = 1'b0;
    lo = 1'b0;
    if (!clr && !halted) begin
      unique case (1'b1)
        ring[0]: begin
          ep = 1'b1;
          lm = adv;
        end
        ring[1]: cp = adv;
        ring[2]: begin
          ce = 1'b1;
          li = adv;
        end
        ring[3]: begin
          unique case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ei = 1'b1;
              lm = adv;
            end
            OP_OUT: begin
              ea = 1'b1;
              lo = adv;
            end
            default: ;
          endcase
        end
        ring[4]: begin
          unique case (opcode)
            OP_LDA: begin
              ce = 1'b1;
              la = adv;
            end
            OP_ADD, OP_SUB: begin
              ce = 1'b1;
              lb = adv;
            end
            default: ;
          endcase
        end
        ring[5]: begin
          unique case (opcode)
            OP_ADD: begin
              la = adv;
              eu = 1'b1;
            end
            OP_SUB: begin
              la = adv;
              eu = 1'b1;
              su = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign tstate = ring;
  assign hlt    = halted;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random + directed stimulus, queue scoreboard
// against a phase/opcode table model of the controller.
module tb_control_sequencer;

  typedef struct packed {
    logic [5:0]  ts;
    logic [11:0] cw;
    logic        h;
  } exp_t;

  localparam int CP = 11, EP = 10, LM = 9, CE = 8, LI = 7, EI = 6;
  localparam int LA = 5, EA = 4, SU = 3, EU = 2, LB = 1, LO = 0;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] opcode;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step;
`endif
  logic [5:0] tstate;
  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
  logic [11:0] act_cw;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   p = 1;
  bit   mh = 1'b0;
  logic [3:0] cur_op;

  control_sequencer dut (
    .clk(clk), .clr(clr), .opcode(opcode),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .tstate(tstate),
    .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei),
    .la(la), .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo),
    .hlt(hlt)
  );

  always #5 clk = ~clk;

  assign act_cw = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};

  function automatic logic [11:0] exp_cw(int ph, logic [3:0] op,
                                         bit hl, bit c, bit st);
    logic [11:0] w;
    w = '0;
    if (c || hl) return w;
    case (ph)
      1: begin w[EP] = 1'b1; w[LM] = st; end
      2: w[CP] = st;
      3: begin w[CE] = 1'b1; w[LI] = st; end
      4: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
          w[EI] = 1'b1; w[LM] = st;
        end
        if (op == 4'hE) begin w[EA] = 1'b1; w[LO] = st; end
      end
      5: begin
        if (op == 4'h0) begin w[CE] = 1'b1; w[LA] = st; end
        if (op == 4'h1 || op == 4'h2) begin
          w[CE] = 1'b1; w[LB] = st;
        end
      end
      6: begin
        if (op == 4'h1 || op == 4'h2) begin
          w[LA] = st; w[EU] = 1'b1; w[SU] = (op == 4'h2);
        end
      end
      default: ;
    endcase
    return w;
  endfunction

  task automatic cyc(bit c, logic [3:0] op, bit st);
    exp_t x;
    clr    = c;
    opcode = op;
`ifdef CTRL_SINGLE_STEP_EN
    step = st;
`else
    st = 1'b1;
`endif
    x.ts = 6'(1 << (p - 1));
    x.cw = exp_cw(p, op, mh, c, st);
    x.h  = mh;
    q.push_back(x);
    if (c) begin
      p  = 1;
      mh = 1'b0;
    end else if (!mh && st) begin
      if (p == 4 && op == 4'hF) mh = 1'b1;
      else p = (p == 6) ? 1 : p + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic instr(logic [3:0] op);
    for (int i = 0; i < 6; i++) cyc(1'b0, op, 1'b1);
  endtask

  function automatic logic [3:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return 4'h0;
    if (r < 4) return 4'h1;
    if (r < 6) return 4'h2;
    if (r == 6) return 4'hE;
    if (r == 7) return 4'hF;
    return 4'($urandom_range(0, 15));
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({tstate, act_cw, hlt} !== e) begin
        errors++;
        $display("FAIL seq t=%0t got ts=%b cw=%b h=%b want ts=%b cw=%b h=%b",
                 $time, tstate, act_cw, hlt, e.ts, e.cw, e.h);
      end
      checks++;
      if ($countones({ep, ce, ei, ea, eu}) > 1) begin
        errors++;
        $display("FAIL busdrv t=%0t got drivers=%b want at most one",
                 $time, {ep, ce, ei, ea, eu});
      end
    end
  end

  initial begin
    clr    = 1'b1;
    opcode = 4'h0;
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b1;
`endif
    @(posedge clk);
    #1;
    p  = 1;
    mh = 1'b0;

    cyc(1'b1, 4'h0, 1'b1);
    instr(4'h0);
    instr(4'h2);
    instr(4'hE);
    for (int i = 0; i < 24; i++) cyc(1'b0, 4'hF, 1'b1);
    cyc(1'b1, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h1, 1'b1);
    cyc(1'b1, 4'h1, 1'b1);
    cyc(1'b0, 4'h1, 1'b1);
    instr(4'h7);
    cyc(1'b0, 4'h0, 1'b1);

`ifdef CTRL_SINGLE_STEP_EN
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
`endif

    cur_op = rand_op();
    for (int i = 0; i < 800; i++) begin
      bit c;
      bit st;
      if (p == 1) cur_op = rand_op();
      c  = ($urandom_range(0, 49) == 0) ||
           (mh && $urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 3) != 0);
      cyc(c, cur_op, st);
    end

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain got pending=%0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
